// File: rtl/dram_pkg.sv
// Shared types and defaults for the DRAM arbiter slice.
package dram_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE  = 2'b00,
      CMD_READ  = 2'b01,
      CMD_WRITE = 2'b10
   } dram_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam int TIMEOUT_LIMIT_DEFAULT = 255;

   // Map a write-enable onto the DRAM command encoding.
   function automatic dram_cmd_e cmd_for(input logic we);
      return we ? CMD_WRITE : CMD_READ;
   endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester, response and DRAM-side signals of the arbiter, bundled.
interface dram_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic [3:0]  i_len;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_len;
   logic [7:0]  d_wdata;
   logic        i_gnt;
   logic        d_gnt;
   logic        rsp_beat;
   logic [7:0]  rsp_data;
   logic        rsp_last;
   logic        rsp_err;
   logic [1:0]  dram_signal;
   logic [31:0] dram_addr_rd;
   logic [31:0] dram_addr_wr;
   logic [7:0]  dram_write_data;
   logic        dram_ready;
   logic [7:0]  dram_result;
   logic        timeout;

   modport slave (
      input  i_req, i_addr, i_len, d_req, d_we, d_addr, d_len, d_wdata,
      input  dram_ready, dram_result,
      output i_gnt, d_gnt, rsp_beat, rsp_data, rsp_last, rsp_err,
      output dram_signal, dram_addr_rd, dram_addr_wr, dram_write_data, timeout
   );

   modport master (
      output i_req, i_addr, i_len, d_req, d_we, d_addr, d_len, d_wdata,
      output dram_ready, dram_result,
      input  i_gnt, d_gnt, rsp_beat, rsp_data, rsp_last, rsp_err,
      input  dram_signal, dram_addr_rd, dram_addr_wr, dram_write_data, timeout
   );
endinterface

// File: rtl/dram_arbiter_rr.sv
// Two-way round-robin pick between the instruction and data requesters.
module rr_arbiter_2 import dram_pkg::*; (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_req,
   input  logic   d_req,
   input  logic   update,
   output logic   pick_valid,
   output owner_e pick_owner
);

   owner_e last_r;

   // A lone requester wins; a tie goes to the side not granted last.
   always_comb begin
      pick_valid = i_req | d_req;
      pick_owner = OWN_I;
      if (i_req && d_req) begin
         pick_owner = (last_r == OWN_I) ? OWN_D : OWN_I;
      end else if (d_req) begin
         pick_owner = OWN_D;
      end else begin
         pick_owner = OWN_I;
      end
   end

   // Remember the winner of every accepted grant; reset favours the data side next.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r <= OWN_I;
      end else if (update) begin
         last_r <= pick_owner;
      end else begin
         last_r <= last_r;
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates instruction and data requesters onto a single-beat DRAM port.
module dram_arbiter import dram_pkg::*; #(
   parameter int TIMEOUT_LIMIT = TIMEOUT_LIMIT_DEFAULT
) (
   input logic           clk,
   input logic           rst,
   dram_arbiter_if.slave bus
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_LIMIT - 1);

   arb_state_e  state_r;
   logic        i_gnt_r, d_gnt_r, we_r;
   logic [31:0] beat_addr_r;
   logic [3:0]  beat_cnt_r;
   logic [7:0]  wait_cnt_r;
   dram_cmd_e   dram_signal_r;
   logic [31:0] dram_addr_rd_r, dram_addr_wr_r;
   logic [7:0]  dram_write_data_r, rsp_data_r;
   logic        rsp_beat_r, rsp_last_r, rsp_err_r, timeout_r;

   logic        pick_valid_s, arb_update_s, start_we_s, issue_we_s;
   owner_e      pick_owner_s;
   logic [31:0] start_addr_s, issue_addr_s;
   logic [3:0]  start_len_s;

   assign arb_update_s = (state_r == ST_IDLE) && pick_valid_s;

   rr_arbiter_2 u_rr (
      .clk        (clk),
      .rst        (rst),
      .i_req      (bus.i_req),
      .d_req      (bus.d_req),
      .update     (arb_update_s),
      .pick_valid (pick_valid_s),
      .pick_owner (pick_owner_s)
   );

   // Transaction parameters of whichever requester the arbiter picks.
   always_comb begin
      start_addr_s = bus.d_addr;
      start_len_s  = bus.d_len;
      start_we_s   = bus.d_we;
      if (pick_owner_s == OWN_I) begin
         start_addr_s = bus.i_addr;
         start_len_s  = bus.i_len;
         start_we_s   = 1'b0;
      end else begin
         start_addr_s = bus.d_addr;
         start_len_s  = bus.d_len;
         start_we_s   = bus.d_we;
      end
   end

   // Address and direction of the next command: fresh grant or following beat.
   always_comb begin
      issue_addr_s = beat_addr_r + 32'd1;
      issue_we_s   = we_r;
      if (state_r == ST_IDLE) begin
         issue_addr_s = start_addr_s;
         issue_we_s   = start_we_s;
      end else begin
         issue_addr_s = beat_addr_r + 32'd1;
         issue_we_s   = we_r;
      end
   end

   // Arbitration FSM with beat sequencing, WAIT timeout and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r           <= ST_IDLE;
         i_gnt_r           <= 1'b0;
         d_gnt_r           <= 1'b0;
         we_r              <= 1'b0;
         beat_addr_r       <= 32'd0;
         beat_cnt_r        <= 4'd0;
         wait_cnt_r        <= 8'd0;
         dram_signal_r     <= CMD_IDLE;
         dram_addr_rd_r    <= 32'd0;
         dram_addr_wr_r    <= 32'd0;
         dram_write_data_r <= 8'd0;
         rsp_beat_r        <= 1'b0;
         rsp_data_r        <= 8'd0;
         rsp_last_r        <= 1'b0;
         rsp_err_r         <= 1'b0;
         timeout_r         <= 1'b0;
      end else begin
         dram_signal_r <= CMD_IDLE;
         rsp_beat_r    <= 1'b0;
         rsp_data_r    <= 8'd0;
         rsp_last_r    <= 1'b0;
         rsp_err_r     <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  i_gnt_r        <= (pick_owner_s == OWN_I);
                  d_gnt_r        <= (pick_owner_s == OWN_D);
                  we_r           <= start_we_s;
                  beat_addr_r    <= start_addr_s;
                  beat_cnt_r     <= start_len_s;
                  dram_signal_r  <= cmd_for(issue_we_s);
                  dram_addr_rd_r <= issue_we_s ? 32'd0 : issue_addr_s;
                  dram_addr_wr_r <= issue_we_s ? issue_addr_s : 32'd0;
                  state_r        <= ST_ISSUE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               wait_cnt_r <= 8'd0;
               if (we_r) begin
                  dram_write_data_r <= bus.d_wdata;
               end else begin
                  dram_write_data_r <= dram_write_data_r;
               end
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.dram_ready) begin
                  rsp_beat_r <= 1'b1;
                  rsp_data_r <= we_r ? 8'd0 : bus.dram_result;
                  if (beat_cnt_r != 4'd0) begin
                     beat_addr_r    <= issue_addr_s;
                     beat_cnt_r     <= beat_cnt_r - 4'd1;
                     dram_signal_r  <= cmd_for(issue_we_s);
                     dram_addr_rd_r <= issue_we_s ? 32'd0 : issue_addr_s;
                     dram_addr_wr_r <= issue_we_s ? issue_addr_s : 32'd0;
                     state_r        <= ST_ISSUE;
                  end else begin
                     rsp_last_r <= 1'b1;
                     state_r    <= ST_RELEASE;
                  end
               end else if (wait_cnt_r == WAIT_LAST) begin
                  rsp_last_r <= 1'b1;
                  rsp_err_r  <= 1'b1;
                  timeout_r  <= 1'b1;
                  state_r    <= ST_RELEASE;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 8'd1;
               end
            end
            ST_RELEASE: begin
               i_gnt_r <= 1'b0;
               d_gnt_r <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               i_gnt_r <= 1'b0;
               d_gnt_r <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.i_gnt           = i_gnt_r;
   assign bus.d_gnt           = d_gnt_r;
   assign bus.rsp_beat        = rsp_beat_r;
   assign bus.rsp_data        = rsp_data_r;
   assign bus.rsp_last        = rsp_last_r;
   assign bus.rsp_err         = rsp_err_r;
   assign bus.dram_signal     = dram_signal_r;
   assign bus.dram_addr_rd    = dram_addr_rd_r;
   assign bus.dram_addr_wr    = dram_addr_wr_r;
   assign bus.dram_write_data = dram_write_data_r;
   assign bus.timeout         = timeout_r;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: transaction-level reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_dram_arbiter;
   import dram_pkg::*;

   localparam int LIMIT = TIMEOUT_LIMIT_DEFAULT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dram_arbiter_if bus();

   dram_arbiter #(.TIMEOUT_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // reference model: who owns the port, where the burst is, when its command went out
   bit          m_busy, m_rel, m_last_d, m_d, m_we;
   logic [31:0] m_addr;
   int          m_left;
   int          m_cmd_cyc = -1000;
   logic        e_gnt_i, e_gnt_d, e_beat, e_last, e_err, e_to;
   logic [1:0]  e_sig;
   logic [31:0] e_ard, e_awr;
   logic [7:0]  e_wd, e_data;

   // DRAM responder and logs for the directed scenarios
   bit          dram_on = 1'b1;
   int          dly_lo = 2, dly_hi = 2;
   int          ready_at = -1;
   logic [33:0] cmd_q[$];
   logic [7:0]  wd_q[$], beat_q[$], res_q[$];
   bit          gnt_q[$];
   bit          prev_wr, prev_gnt;
   int          cmd_cyc_seen, last_cyc;
   logic [7:0]  wbytes[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
   int          wd_idx;
   bit          wd_mode;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic start_cmd();
      m_cmd_cyc = cyc;
      e_sig = m_we ? 2'b10 : 2'b01;
      e_ard = m_we ? 32'd0 : m_addr;
      e_awr = m_we ? m_addr : 32'd0;
   endtask

   // Expected outputs for the cycle that begins at this edge, from inputs seen at the edge.
   task automatic model_step();
      e_sig = 2'b00; e_beat = 1'b0; e_data = 8'd0; e_last = 1'b0; e_err = 1'b0;
      if (rst) begin
         m_busy = 1'b0; m_rel = 1'b0; m_last_d = 1'b0; m_cmd_cyc = -1000;
         e_gnt_i = 1'b0; e_gnt_d = 1'b0; e_ard = 32'd0; e_awr = 32'd0;
         e_wd = 8'd0; e_to = 1'b0;
      end else if (!m_busy) begin
         if (bus.i_req || bus.d_req) begin
            m_d = (bus.i_req && bus.d_req) ? !m_last_d : bus.d_req;
            m_last_d = m_d;
            m_busy = 1'b1;
            e_gnt_i = !m_d;
            e_gnt_d = m_d;
            if (m_d) begin
               m_addr = bus.d_addr; m_left = int'(bus.d_len); m_we = bus.d_we;
            end else begin
               m_addr = bus.i_addr; m_left = int'(bus.i_len); m_we = 1'b0;
            end
            start_cmd();
         end
      end else if (m_rel) begin
         m_busy = 1'b0; m_rel = 1'b0; e_gnt_i = 1'b0; e_gnt_d = 1'b0;
      end else if (cyc == m_cmd_cyc + 1) begin
         if (m_we) e_wd = bus.d_wdata;
      end else if (bus.dram_ready) begin
         e_beat = 1'b1;
         e_data = m_we ? 8'd0 : bus.dram_result;
         if (m_left > 0) begin
            m_addr = m_addr + 32'd1;
            m_left--;
            start_cmd();
         end else begin
            e_last = 1'b1;
            m_rel = 1'b1;
         end
      end else if (cyc - 1 - m_cmd_cyc == LIMIT) begin
         e_last = 1'b1; e_err = 1'b1; e_to = 1'b1; m_rel = 1'b1;
      end
   endtask

   task automatic compare_all();
      chk("i_gnt", bus.i_gnt, e_gnt_i);
      chk("d_gnt", bus.d_gnt, e_gnt_d);
      chk("dram_signal", bus.dram_signal, e_sig);
      chk("dram_addr_rd", bus.dram_addr_rd, e_ard);
      chk("dram_addr_wr", bus.dram_addr_wr, e_awr);
      chk("dram_write_data", bus.dram_write_data, e_wd);
      chk("rsp_beat", bus.rsp_beat, e_beat);
      chk("rsp_data", bus.rsp_data, e_data);
      chk("rsp_last", bus.rsp_last, e_last);
      chk("rsp_err", bus.rsp_err, e_err);
      chk("timeout", bus.timeout, e_to);
   endtask

   // One clock: sample after the edge, check against the model, log, answer as DRAM.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_step();
      compare_all();
      if (prev_wr) wd_q.push_back(bus.dram_write_data);
      prev_wr = (bus.dram_signal == 2'b10);
      if (bus.dram_signal != 2'b00) begin
         cmd_q.push_back({bus.dram_signal,
                          (bus.dram_signal == 2'b10) ? bus.dram_addr_wr : bus.dram_addr_rd});
         cmd_cyc_seen = cyc;
         ready_at = cyc + $urandom_range(dly_hi, dly_lo);
      end
      if (bus.rsp_beat) beat_q.push_back(bus.rsp_data);
      if (bus.rsp_last) last_cyc = cyc;
      if ((bus.i_gnt || bus.d_gnt) && !prev_gnt) gnt_q.push_back(bus.d_gnt);
      prev_gnt = bus.i_gnt || bus.d_gnt;
      bus.dram_ready = dram_on && (cyc == ready_at);
      if (bus.dram_ready) begin
         bus.dram_result = 8'($urandom);
         res_q.push_back(bus.dram_result);
      end
   endtask

   task automatic clear_logs();
      cmd_q.delete(); wd_q.delete(); beat_q.delete(); res_q.delete(); gnt_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.i_req = 1'b0; bus.d_req = 1'b0; bus.dram_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      ready_at = -1;
      clear_logs();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_gnts"}, {bus.i_gnt, bus.d_gnt}, 32'd0);
      chk({tag, "_rsp"}, {bus.rsp_beat, bus.rsp_last, bus.rsp_err, bus.rsp_data}, 32'd0);
      chk({tag, "_sig"}, bus.dram_signal, 32'd0);
      chk({tag, "_ard"}, bus.dram_addr_rd, 32'd0);
      chk({tag, "_awr"}, bus.dram_addr_wr, 32'd0);
      chk({tag, "_wd_to"}, {bus.dram_write_data, bus.timeout}, 32'd0);
   endtask

   task automatic wait_gnt(input int budget);
      bit got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         tick();
         if (bus.i_gnt || bus.d_gnt) got = 1'b1;
      end
      chk("wait_gnt", got, 32'd1);
   endtask

   task automatic wait_last(input int budget);
      bit got = 1'b0;
      for (int k = 0; k < budget && !got; k++) begin
         tick();
         if (wd_mode && bus.rsp_beat && wd_idx < 3) begin
            wd_idx++;
            bus.d_wdata = wbytes[wd_idx];
         end
         if (bus.rsp_last) got = 1'b1;
      end
      chk("wait_last", got, 32'd1);
   endtask

   initial begin
      bus.i_req = 1'b0; bus.i_addr = 32'd0; bus.i_len = 4'd0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_len = 4'd0;
      bus.d_wdata = 8'd0; bus.dram_ready = 1'b0; bus.dram_result = 8'd0;

      // reset state
      do_reset();
      check_zero("reset");

      // data-side write burst of four beats at 0x100
      dly_lo = 2; dly_hi = 2;
      wd_mode = 1'b1; wd_idx = 0;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_len = 4'd3;
      bus.d_wdata = wbytes[0];
      wait_gnt(5);
      bus.d_req = 1'b0;
      wait_last(60);
      wd_mode = 1'b0;
      chk("wr_cmds", cmd_q.size(), 32'd4);
      chk("wr_beats", beat_q.size(), 32'd4);
      for (int k = 0; k < 4 && k < cmd_q.size() && k < wd_q.size(); k++) begin
         chk("wr_cmd", cmd_q[k], {2'b10, 32'h100 + 32'(k)});
         chk("wr_byte", wd_q[k], wbytes[k]);
      end
      chk("gnt_in_release", bus.d_gnt, 32'd1);
      tick();
      chk("gnt_after_release", bus.d_gnt, 32'd0);

      // simultaneous requests alternate, data side first after reset
      do_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.i_len = 4'd0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h20; bus.d_len = 4'd0;
      for (int t = 0; t < 4; t++) wait_last(20);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      chk("rr_count", gnt_q.size() >= 4, 32'd1);
      for (int k = 0; k < 4 && k < gnt_q.size(); k++)
         chk("rr_order", gnt_q[k], (k % 2 == 0) ? 32'd1 : 32'd0);

      // instruction read wrapping past 0xFFFFFFFF
      do_reset();
      dly_lo = 1; dly_hi = 3;
      bus.i_req = 1'b1; bus.i_addr = 32'hFFFF_FFFE; bus.i_len = 4'd2;
      wait_gnt(5);
      bus.i_req = 1'b0;
      wait_last(40);
      chk("wrap_cmds", cmd_q.size(), 32'd3);
      if (cmd_q.size() == 3) begin
         chk("wrap_a0", cmd_q[0], {2'b01, 32'hFFFF_FFFE});
         chk("wrap_a1", cmd_q[1], {2'b01, 32'hFFFF_FFFF});
         chk("wrap_a2", cmd_q[2], {2'b01, 32'h0000_0000});
      end
      chk("wrap_beats", beat_q.size(), 32'd3);
      for (int k = 0; k < 3 && k < beat_q.size() && k < res_q.size(); k++)
         chk("wrap_data", beat_q[k], res_q[k]);

      // DRAM never answers: abort after the WAIT limit, flag sticks
      do_reset();
      dram_on = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40; bus.d_len = 4'd0;
      wait_gnt(5);
      bus.d_req = 1'b0;
      wait_last(400);
      chk("to_err", bus.rsp_err, 32'd1);
      chk("to_beat", bus.rsp_beat, 32'd0);
      chk("to_latency", last_cyc - cmd_cyc_seen, 32'd256);
      tick(); tick(); tick();
      chk("to_sticky", bus.timeout, 32'd1);
      dram_on = 1'b1;
      bus.i_req = 1'b1; bus.i_addr = 32'h80; bus.i_len = 4'd0;
      wait_gnt(5);
      bus.i_req = 1'b0;
      wait_last(20);
      chk("after_to_ok", {bus.rsp_beat, bus.rsp_err, bus.timeout}, 32'b101);

      // reset in the WAIT of beat 2, then a stray ready
      do_reset();
      dly_lo = 3; dly_hi = 3;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_len = 4'd3;
      bus.d_wdata = 8'h5A;
      for (int k = 0; k < 40 && cmd_q.size() < 2; k++) tick();
      chk("rst_setup", cmd_q.size(), 32'd2);
      tick();
      rst = 1'b1; bus.d_req = 1'b0; bus.dram_ready = 1'b1;
      tick();
      rst = 1'b0; bus.dram_ready = 1'b1;
      check_zero("mid_rst");
      tick();
      check_zero("stray_ready");

      // ready pulses in IDLE and ISSUE are ignored
      do_reset();
      dly_lo = 2; dly_hi = 2;
      bus.dram_ready = 1'b1;
      tick();
      bus.i_req = 1'b1; bus.i_addr = 32'h300; bus.i_len = 4'd1;
      tick();
      bus.i_req = 1'b0; bus.dram_ready = 1'b1;
      wait_last(40);
      chk("ign_cmds", cmd_q.size(), 32'd2);
      chk("ign_beats", beat_q.size(), 32'd2);
      if (cmd_q.size() == 2) chk("ign_a1", cmd_q[1], {2'b01, 32'h301});

      // randomized traffic against the model
      do_reset();
      dly_lo = 1; dly_hi = 4;
      for (int n = 0; n < 3000; n++) begin
         tick();
         rst = ($urandom_range(0, 499) == 0);
         bus.i_req = ($urandom_range(0, 3) == 0);
         bus.d_req = ($urandom_range(0, 3) == 0);
         bus.i_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
         bus.d_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
         bus.i_len = 4'($urandom_range(0, 3));
         bus.d_len = 4'($urandom_range(0, 3));
         bus.d_we = 1'($urandom_range(0, 1));
         bus.d_wdata = 8'($urandom);
         if ($urandom_range(0, 15) == 0) bus.dram_ready = 1'b1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter TIMEOUT_LIMIT, default 255, gives the WAIT cycles without dram_ready before a transaction aborts.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_req / i_addr / i_len  input  1/32/4  instruction-side read request: start byte address and beat count minus 1 (1..16 beats).
REQ-005 d_req / d_we / d_addr / d_len / d_wdata  input  1/1/32/4/8  data-side request: read (d_we=0) or write (d_we=1), address, beat count minus 1, and current write byte.
REQ-006 i_gnt / d_gnt  output  1/1  grant; at most one is high; held for the whole transaction.
REQ-007 rsp_beat / rsp_data / rsp_last / rsp_err  output  1/8/1/1  owner response: beat done, read byte, final beat, aborted.
REQ-008 dram_signal  output  2  DRAM command: 00 idle, 01 read, 10 write.
REQ-009 dram_addr_rd / dram_addr_wr / dram_write_data  output  32/32/8  DRAM read address, write address and write byte.
REQ-010 dram_ready / dram_result  input  1/8  DRAM one-cycle completion pulse and read byte.
REQ-011 timeout  output  1  sticky flag: a DRAM access exceeded TIMEOUT_LIMIT.

Function
REQ-012 FSM states: IDLE, ISSUE, WAIT, RELEASE; all outputs are registered.
REQ-013 In IDLE with exactly one request high, that requester is granted: next cycle its gnt=1 and the state is ISSUE.
REQ-014 Ties in IDLE go to the requester not granted last (round-robin); after reset the data side wins the first tie.
REQ-015 At the grant edge, addr, len and we are latched into a beat address and a beat counter; requester inputs are ignored until the next IDLE, except d_wdata.
REQ-016 ISSUE lasts exactly one cycle: dram_signal=01 (read) or 10 (write), and the active address port = beat address.
REQ-017 On a write, dram_write_data = d_wdata sampled in the ISSUE cycle.
REQ-018 WAIT: dram_signal=00; the address and write data stay stable; the inactive address port = 0.
REQ-019 dram_ready is honoured only in WAIT and ignored in IDLE, ISSUE and RELEASE.
REQ-020 On dram_ready in WAIT: next cycle rsp_beat=1 for one cycle; for reads rsp_data = the captured dram_result.
REQ-021 If beats remain after that dram_ready: beat address +1 (32-bit, 0xFFFFFFFF wraps to 0), counter -1, next state ISSUE.
REQ-022 If no beats remain: next state RELEASE, with rsp_last=1 in the same cycle as the final rsp_beat.
REQ-023 The data requester presents the next write byte in the cycle after each rsp_beat.
REQ-024 RELEASE lasts one cycle with gnt still high; next cycle IDLE, gnt=0, and arbitration resumes (IDLE -> ISSUE minimum turnaround per transaction).
REQ-025 WAIT counts cycles in an 8-bit counter that resets on each ISSUE.
REQ-026 On reaching TIMEOUT_LIMIT: next state RELEASE with rsp_last=1, rsp_err=1, rsp_beat=0; timeout sets and stays set until rst.
REQ-027 A requester dropping req mid-transaction does not abort it; the transaction completes.
REQ-028 Minimum single-beat latency, grant to rsp_last: ISSUE + WAIT(n) + 1 cycle, with n >= 1.

Reset
REQ-029 rst in any state forces IDLE next cycle, mid-transaction included, with no further DRAM command.
REQ-030 Reset values: gnts, rsp_*, timeout = 0; dram_signal=00; all addresses and data = 0; last-granted = instruction side.

Structure
REQ-031 Shared package dram_pkg holds dram_cmd_e (IDLE/READ/WRITE encodings), arb_state_e, owner_e and the default TIMEOUT_LIMIT.
REQ-032 Sub-module rr_arbiter_2 holds the two-way round-robin pick and the last-granted register; the FSM, counters and datapath stay in dram_arbiter.

Verification
REQ-033 d_req only, write, addr 0x100, len 3, DRAM ready 2 cycles after each command -> four 10 commands at 0x100..0x103 with bytes written in order, rsp_last on beat 4, d_gnt drops after RELEASE.
REQ-034 i_req and d_req rise together after reset -> d_gnt first; both re-request -> i_gnt next; alternation continues.
REQ-035 i_req read, addr 0xFFFFFFFE, len 2 -> read addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; rsp_data matches the DRAM bytes.
REQ-036 DRAM never asserts ready -> after 255 WAIT cycles rsp_err=1 and rsp_last=1, timeout=1 sticky, next request still served.
REQ-037 rst asserted in WAIT of beat 2 -> next cycle IDLE, all outputs zero, stray dram_ready ignored.
REQ-038 dram_ready pulsed in IDLE and ISSUE -> no rsp_beat, beat counter unchanged.
